array_table_writer: RTL and testbench

//  Owns and writes a SIZE-entry table of data_t {value, valid} records from data_types_pkg.

---
 rtl/array_table_writer.sv | 176 +++++++++++++++++
 tb/tb_array_table_writer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/array_table_writer.sv
// Table owner for an external array_match: serves insert/delete/clear requests over
// a valid-ready request/response handshake and keeps an occupancy count.
package data_types_pkg;
  localparam int DATA_WIDTH = 4;
  typedef struct packed {
    logic [DATA_WIDTH-1:0] value;
    logic                  valid;
  } data_t;
endpackage

module array_table_writer
  import data_types_pkg::*;
#(
  parameter  int SIZE  = 8,
  parameter  int WIDTH = 4,
  localparam int IDXW  = $clog2(SIZE),
  localparam int CNTW  = $clog2(SIZE + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [1:0]             req_op,
  input  logic [WIDTH-1:0]       req_value,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [1:0]             rsp_status,
  output logic [IDXW-1:0]        rsp_index,
  output data_t [SIZE-1:0]       entries_o,
  output logic [WIDTH-1:0]       match_value_o,
  input  logic [SIZE-1:0]        match_mask_i,
  output logic [CNTW-1:0]        count_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [1:0] OP_INSERT = 2'b00;
  localparam logic [1:0] OP_DELETE = 2'b01;
  localparam logic [1:0] OP_CLEAR  = 2'b10;

  localparam logic [1:0] RS_OK       = 2'b00;
  localparam logic [1:0] RS_FULL     = 2'b01;
  localparam logic [1:0] RS_DUP      = 2'b10;
  localparam logic [1:0] RS_NOTFOUND = 2'b11;

  logic [1:0]       state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] match_value_q, match_value_d;
  data_t [SIZE-1:0] table_q, table_d;
  logic [CNTW-1:0]  count_q, count_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [1:0]       rsp_status_q, rsp_status_d;
  logic [IDXW-1:0]  rsp_index_q, rsp_index_d;

  logic             mask_any, free_any;
  logic [IDXW-1:0]  mask_idx, free_idx;
  logic [CNTW-1:0]  mask_pop;

  // Lowest matching entry, lowest free entry and match popcount.
  always_comb begin
    mask_any = 1'b0;
    mask_idx = '0;
    free_any = 1'b0;
    free_idx = '0;
    mask_pop = '0;
    for (int i = SIZE - 1; i >= 0; i--) begin
      if (match_mask_i[i]) begin
        mask_any = 1'b1;
        mask_idx = IDXW'(i);
      end
      if (!table_q[i].valid) begin
        free_any = 1'b1;
        free_idx = IDXW'(i);
      end
      mask_pop = mask_pop + CNTW'(match_mask_i[i]);
    end
  end

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    match_value_d = match_value_q;
    table_d       = table_q;
    count_d       = count_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_status_d  = rsp_status_q;
    rsp_index_d   = rsp_index_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          op_d          = req_op;
          match_value_d = req_value;
          state_d       = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_status_d = RS_OK;
        rsp_index_d  = '0;
        case (op_q)
          OP_INSERT: begin
            if (mask_any) begin
              rsp_status_d = RS_DUP;
              rsp_index_d  = mask_idx;
            end else if (count_q == CNTW'(SIZE) || !free_any) begin
              rsp_status_d = RS_FULL;
            end else begin
              table_d[free_idx].value = match_value_q;
              table_d[free_idx].valid = 1'b1;
              count_d                 = count_q + 1'b1;
              rsp_index_d             = free_idx;
            end
          end
          OP_DELETE: begin
            if (!mask_any) begin
              rsp_status_d = RS_NOTFOUND;
            end else begin
              for (int i = 0; i < SIZE; i++) begin
                if (match_mask_i[i]) table_d[i] = '0;
              end
              // Mask only covers valid entries, but never let the count wrap.
              count_d     = (mask_pop > count_q) ? '0 : count_q - mask_pop;
              rsp_index_d = mask_idx;
            end
          end
          OP_CLEAR: begin
            table_d = '0;
            count_d = '0;
          end
          default: ;
        endcase
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      op_q          <= '0;
      match_value_q <= '0;
      table_q       <= '0;
      count_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_status_q  <= '0;
      rsp_index_q   <= '0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      match_value_q <= match_value_d;
      table_q       <= table_d;
      count_q       <= count_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_status_q  <= rsp_status_d;
      rsp_index_q   <= rsp_index_d;
    end
  end

  assign req_ready     = (state_q == ST_IDLE);
  assign rsp_valid     = rsp_valid_q;
  assign rsp_status    = rsp_status_q;
  assign rsp_index     = rsp_index_q;
  assign entries_o     = table_q;
  assign match_value_o = match_value_q;
  assign count_o       = count_q;

endmodule

// File: tb/tb_array_table_writer.sv
// Directed plus randomized bench for array_table_writer; an array_match model closes
// the mask loop and a value/valid array model predicts every response.
module tb_array_table_writer;
  import data_types_pkg::*;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            req_valid, req_ready, rsp_valid, rsp_ready;
  logic [1:0]      req_op, rsp_status;
  logic [3:0]      req_value, match_value_o;
  logic [2:0]      rsp_index;
  data_t [7:0]     entries_o;
  logic [7:0]      match_mask_i, mask_force;
  logic [3:0]      count_o;

  int checks = 0;
  int failures = 0;

  logic [3:0] m_val [8];
  bit         m_vld [8];
  int         m_cnt;

  always #5 clk = ~clk;

  array_table_writer #(.SIZE(8), .WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_value(req_value),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status), .rsp_index(rsp_index),
    .entries_o(entries_o), .match_value_o(match_value_o), .match_mask_i(match_mask_i),
    .count_o(count_o)
  );

  // External array_match: valid-gated equality, plus a backdoor to fake extra matches.
  always_comb begin
    for (int i = 0; i < 8; i++)
      match_mask_i[i] = (entries_o[i].valid && entries_o[i].value == match_value_o) || mask_force[i];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin m_val[i] = '0; m_vld[i] = 0; end
    m_cnt = 0;
  endtask

  function automatic logic [39:0] exp_table();
    logic [39:0] e = '0;
    for (int i = 0; i < 8; i++) e[i*5 +: 5] = {m_val[i], m_vld[i]};
    return e;
  endfunction

  // Apply one request to the model; returns expected status and index.
  task automatic model_exec(input logic [1:0] op, input logic [3:0] val, input logic [7:0] frc,
                            output logic [1:0] st, output int idx);
    int hit = -1;
    int hole = -1;
    st = 2'b00; idx = 0;
    for (int i = 7; i >= 0; i--) begin
      if ((m_vld[i] && m_val[i] == val) || frc[i]) hit = i;
      if (!m_vld[i]) hole = i;
    end
    case (op)
      2'b00: begin
        if (hit >= 0) begin st = 2'b10; idx = hit; end
        else if (m_cnt == 8) st = 2'b01;
        else begin m_val[hole] = val; m_vld[hole] = 1; m_cnt++; idx = hole; end
      end
      2'b01: begin
        if (hit < 0) st = 2'b11;
        else begin
          idx = hit;
          for (int i = 0; i < 8; i++)
            if ((m_vld[i] && m_val[i] == val) || frc[i]) begin
              if (m_vld[i]) m_cnt--;
              m_vld[i] = 0; m_val[i] = '0;
            end
        end
      end
      2'b10: model_reset();
      default: ;
    endcase
  endtask

  task automatic send(input logic [1:0] op, input logic [3:0] val, input logic [7:0] frc, input bit ack);
    logic [1:0] est;
    int eidx;
    int n;
    model_exec(op, val, frc, est, eidx);
    @(negedge clk);
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1; req_op = op; req_value = val; mask_force = frc;
    @(posedge clk);
    #1 req_valid = 0;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 8) begin @(negedge clk); n++; end
    chk("rsp_valid_timeout", rsp_valid, 1);
    chk("rsp_status", rsp_status, est);
    chk("rsp_index", rsp_index, eidx);
    chk("count", count_o, m_cnt);
    chk("table", entries_o, exp_table());
    chk("match_value", match_value_o, val);
    $display("txn op=%0d val=%0d status=%0d idx=%0d count=%0d (exp status=%0d idx=%0d count=%0d)",
             op, val, rsp_status, rsp_index, count_o, est, eidx, m_cnt);
    if (ack) begin
      @(negedge clk);
      rsp_ready = 1;
      @(posedge clk);
      #1 rsp_ready = 0;
      mask_force = '0;
      chk("rsp_drop", rsp_valid, 0);
    end
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_status"}, rsp_status, 0);
    chk({tag, "_rsp_index"}, rsp_index, 0);
    chk({tag, "_req_ready"}, req_ready, 1);
    chk({tag, "_count"}, count_o, 0);
    chk({tag, "_table"}, entries_o, 40'h0);
    chk({tag, "_match_value"}, match_value_o, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    #1 reset_checks("reset");
    @(negedge clk);
    rst_n = 1;
    model_reset();
  endtask

  task automatic quiet_after_reset(input string tag);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk(tag, rsp_valid, 0);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] st0;
    logic [2:0] ix0;
    int r;
    rst_n = 0; req_valid = 0; rsp_ready = 0; req_op = 0; req_value = 0; mask_force = '0;
    model_reset();
    repeat (2) @(negedge clk);
    reset_checks("por");
    rst_n = 1;

    // Basic inserts, duplicate, missing delete
    send(2'b00, 4'd3, 8'h0, 1);
    send(2'b00, 4'd5, 8'h0, 1);
    send(2'b00, 4'd10, 8'h0, 1);
    chk("entry2_value", entries_o[2].value, 4'd10);
    chk("entry2_valid", entries_o[2].valid, 1);
    send(2'b00, 4'd5, 8'h0, 1);
    send(2'b01, 4'd7, 8'h0, 1);

    // Fill, overflow, hole reuse
    do_reset();
    for (int v = 1; v <= 8; v++) send(2'b00, 4'(v), 8'h0, 1);
    send(2'b00, 4'd9, 8'h0, 1);
    send(2'b01, 4'd5, 8'h0, 1);
    send(2'b00, 4'd12, 8'h0, 1);
    chk("hole_reuse_index", rsp_index, 3'd4);

    // Duplicate match faked at entry 5: both matching entries cleared
    do_reset();
    send(2'b00, 4'd3, 8'h0, 1);
    for (int v = 4; v <= 8; v++) send(2'b00, 4'(v), 8'h0, 1);
    send(2'b01, 4'd3, 8'h20, 1);
    chk("dup_delete_count", count_o, 4'd4);

    // Response back-pressure: everything holds, new requests ignored
    send(2'b00, 4'd11, 8'h0, 0);
    st0 = rsp_status; ix0 = rsp_index;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      req_valid = 1; req_op = 2'b00; req_value = 4'd2;
      #1;
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_status", rsp_status, st0);
      chk("bp_index", rsp_index, ix0);
      chk("bp_req_ready", req_ready, 0);
    end
    @(negedge clk);
    req_valid = 0; rsp_ready = 1;
    @(posedge clk);
    #1 rsp_ready = 0;
    chk("bp_count_kept", count_o, m_cnt);
    send(2'b10, 4'd0, 8'h0, 1);
    send(2'b11, 4'd6, 8'h0, 1);

    // Reset during EXEC
    send(2'b00, 4'd1, 8'h0, 1);
    @(negedge clk);
    req_valid = 1; req_op = 2'b00; req_value = 4'd9;
    @(posedge clk);
    #1 req_valid = 0; rst_n = 0;
    #1 reset_checks("rst_exec");
    @(negedge clk);
    rst_n = 1; model_reset();
    quiet_after_reset("rst_exec_no_rsp");

    // Reset during RESP
    send(2'b00, 4'd4, 8'h0, 0);
    #2 rst_n = 0;
    #1 reset_checks("rst_resp");
    @(negedge clk);
    rst_n = 1; model_reset();
    quiet_after_reset("rst_resp_no_rsp");

    // Randomized traffic against the model
    for (int k = 0; k < 80; k++) begin
      r = $urandom_range(0, 19);
      if (r < 11)       send(2'b00, 4'($urandom_range(0, 15)), 8'h0, 1);
      else if (r < 18)  send(2'b01, 4'($urandom_range(0, 15)), 8'h0, 1);
      else if (r == 18) send(2'b10, 4'($urandom_range(0, 15)), 8'h0, 1);
      else              send(2'b11, 4'($urandom_range(0, 15)), 8'h0, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
